// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 block engine, one round per clock.
// Encrypt and decrypt share the state register and round counter.
module aes_iter_core #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic                  in_mode,
  input  logic [128*(NR+1)-1:0] round_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  out_mode,
  output logic                  busy
);
  localparam int RW = $clog2(NR + 1);

  if (NR != NK + 6 || !(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_cfg
    $error("aes_iter_core: NR must equal NK+6 with NK in {4,6,8}");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as a^254 by square-and-multiply; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]}
             ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
      ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s,
                                             input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox(s[127-8*i -: 8])
                            : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                              input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s,
                                            input logic inv);
    logic [31:0] cf;
    logic [127:0] o;
    logic [7:0] b;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) begin
        b = '0;
        for (int k = 0; k < 4; k++)
          b = b ^ gmul(cf[31-8*((k-j+4)%4) -: 8],
                       s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+j) -: 8] = b;
      end
    return o;
  endfunction

  state_t        state;
  logic [RW-1:0] rnd;
  logic [127:0]  st;
  logic          mode;

  logic          kmode;
  logic [RW-1:0] kidx;
  logic [127:0]  rkey;
  logic [127:0]  enc_pre, enc_nxt, dec_pre, dec_nxt;
  logic [127:0]  rnd_nxt, fin_nxt;

  // Decrypt walks the schedule backwards; one index mux serves both.
  always_comb begin
    kmode = (state == S_IDLE) ? in_mode : mode;
    kidx  = kmode ? RW'(NR) - rnd : rnd;
    rkey  = round_keys[(NR + 1 - int'(kidx)) * 128 - 1 -: 128];
  end

  always_comb begin
    enc_pre = shift_rows(sub_bytes(st, 1'b0), 1'b0);
    enc_nxt = mix_cols(enc_pre, 1'b0) ^ rkey;
    dec_pre = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rkey;
    dec_nxt = mix_cols(dec_pre, 1'b1);
    rnd_nxt = mode ? dec_nxt : enc_nxt;
    fin_nxt = mode ? dec_pre : enc_pre ^ rkey;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rnd       <= '0;
      st        <= '0;
      mode      <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            st       <= in_data ^ rkey;
            mode     <= in_mode;
            rnd      <= RW'(1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_ROUND;
          end
        end
        S_ROUND: begin
          st  <= rnd_nxt;
          rnd <= rnd + RW'(1);
          if (rnd == RW'(NR - 1)) state <= S_FINAL;
        end
        S_FINAL: begin
          out_data  <= fin_nxt;
          out_mode  <= mode;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed + random checks of aes_iter_core
// for AES-128/192/256 against FIPS-197 vectors and a table model.
module tb_aes_iter_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [2:0]           iv;
  logic [127:0]         in_data;
  logic                 in_mode;
  logic                 out_ready;
  logic [128*11-1:0]    rk4;
  logic [128*13-1:0]    rk6;
  logic [128*15-1:0]    rk8;
  logic                 ir [3];
  logic                 ov [3];
  logic                 om [3];
  logic                 bz [3];
  logic [127:0]         od [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_core #(.NK(4), .NR(10)) u4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_mode(in_mode), .round_keys(rk4),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_mode(om[0]), .busy(bz[0]));

  aes_iter_core #(.NK(6), .NR(12)) u6 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_mode(in_mode), .round_keys(rk6),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_mode(om[1]), .busy(bz[1]));

  aes_iter_core #(.NK(8), .NR(14)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_mode(in_mode), .round_keys(rk8),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_mode(om[2]), .busy(bz[2]));

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                   input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from brute-force inverse search plus bitwise affine map.
  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key,
                                             input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [128*15-1:0] flat(input logic [255:0] key,
                                             input int nk);
    logic [128*15-1:0] f;
    f = '0;
    for (int k = 0; k <= nk + 6; k++)
      f[(nk+7-k)*128-1 -: 128] = round_key(key, nk, k);
    return f;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s,
                                        input bit inv);
    logic [7:0] m [16];
    logic [7:0] b;
    logic [127:0] o;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09, 8'h09, 8'h0e, 8'h0b, 8'h0d,
                   8'h0d, 8'h09, 8'h0e, 8'h0b, 8'h0b, 8'h0d, 8'h09, 8'h0e};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
                   8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int k = 0; k < 4; k++)
          b = b ^ gm(m[4*r+k], s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = b;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt,
                                             input logic [255:0] key,
                                             input int nk);
    logic [127:0] s, t;
    int nr;
    nr = nk + 6;
    s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] =
          sb[s[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]];
      if (r < nr) t = mixc(t, 1'b0);
      s = t ^ round_key(key, nk, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct,
                                             input logic [255:0] key,
                                             input int nk);
    logic [127:0] s, t;
    int nr;
    nr = nk + 6;
    s = ct ^ round_key(key, nk, nr);
    for (int r = nr - 1; r >= 0; r--) begin
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] =
          isb[s[127-8*(4*(((i/4)-(i%4)+4)%4)+(i%4)) -: 8]];
      t = t ^ round_key(key, nk, r);
      if (r > 0) t = mixc(t, 1'b1);
      s = t;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int u, input logic [127:0] d,
                           input logic m, output logic [127:0] res,
                           output logic rmode, output int lat);
    int n;
    in_data = d;
    in_mode = m;
    out_ready = 1'b1;
    iv[u] = 1'b1;
    n = 0;
    while (!ir[u] && n < 50) begin step(); n++; end
    step();
    iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 40) begin step(); lat++; end
    res = od[u];
    rmode = om[u];
    step();
  endtask

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [255:0] key;
    logic [128*15-1:0] fk;
    logic [127:0] res, b1, b2, hold;
    logic [127:0] bd [4];
    logic [127:0] got [4];
    logic bm [4];
    int acc [4];
    logic rm;
    int lat, n, r, seen;

    reset = 1'b1;
    iv = '0;
    in_data = '0;
    in_mode = 1'b0;
    out_ready = 1'b0;
    build_tables();
    for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
    fk = flat(key, 4); rk4 = fk[128*11-1:0];
    fk = flat(key, 6); rk6 = fk[128*13-1:0];
    fk = flat(key, 8); rk8 = fk;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 160'({ov[0], om[0], bz[0], ir[0]}), 160'(0));
    check("rst_data", 160'(od[0]), 160'(0));
    reset = 1'b0;
    step();
    check("rel_ready", 160'({ir[0], bz[0]}), 160'(2'b10));

    run_block(0, PT, 1'b0, res, rm, lat);
    check("e128_data", 160'(res), 160'(C128));
    check("e128_lat", 160'(lat), 160'(10));
    check("e128_mode", 160'(rm), 160'(0));
    run_block(0, C128, 1'b1, res, rm, lat);
    check("d128_data", 160'(res), 160'(PT));
    check("d128_mode", 160'(rm), 160'(1));

    run_block(1, PT, 1'b0, res, rm, lat);
    check("e192_data", 160'(res), 160'(C192));
    check("e192_lat", 160'(lat), 160'(12));
    run_block(1, C192, 1'b1, res, rm, lat);
    check("d192_data", 160'(res), 160'(PT));
    run_block(2, PT, 1'b0, res, rm, lat);
    check("e256_data", 160'(res), 160'(C256));
    check("e256_lat", 160'(lat), 160'(14));
    run_block(2, C256, 1'b1, res, rm, lat);
    check("d256_data", 160'(res), 160'(PT));

    // Backpressure with a second block pending the whole time.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    b2 = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    in_data = b1;
    in_mode = 1'b0;
    iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 50) begin step(); n++; end
    step();
    in_data = b2;
    in_mode = 1'b1;
    n = 0;
    while (!ov[0] && n < 40) begin step(); n++; end
    hold = od[0];
    check("bp_first", 160'(hold), 160'(model_enc(b1, key, 4)));
    for (int k = 0; k < 7; k++) begin
      step();
      check("bp_hold", 160'({od[0], ov[0], ir[0], bz[0]}),
            160'({hold, 3'b100}));
    end
    out_ready = 1'b1;
    step();
    check("bp_idle", 160'({ov[0], ir[0], bz[0]}), 160'(3'b010));
    step();
    check("bp_accept2", 160'({ir[0], bz[0]}), 160'(2'b01));
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin step(); n++; end
    check("bp_second", 160'({od[0], om[0]}),
          160'({model_dec(b2, key, 4), 1'b1}));
    step();

    // Reset in the middle of a block.
    b1 = {$urandom, $urandom, $urandom, $urandom};
    in_data = b1;
    in_mode = 1'b0;
    iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 50) begin step(); n++; end
    step();
    iv[0] = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    iv[0] = 1'b1;
    #1;
    check("mid_rst", 160'({od[0], ov[0], om[0], bz[0], ir[0]}), 160'(0));
    step();
    step();
    iv[0] = 1'b0;
    reset = 1'b0;
    step();
    check("mid_rel", 160'({ir[0], bz[0], ov[0]}), 160'(3'b100));
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      if (ov[0] || bz[0]) seen++;
      step();
    end
    check("mid_no_out", 160'(seen), 160'(0));
    b2 = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, b2, 1'b0, res, rm, lat);
    check("mid_next", 160'(res), 160'(model_enc(b2, key, 4)));

    // Back-to-back stream with out_ready tied high.
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bd[b] = {$urandom, $urandom, $urandom, $urandom};
      bm[b] = 1'($urandom_range(0, 1));
      got[b] = '0;
      acc[b] = 0;
    end
    r = 0;
    for (int b = 0; b < 4; b++) begin
      in_data = bd[b];
      in_mode = bm[b];
      iv[0] = 1'b1;
      n = 0;
      while (!ir[0] && n < 50) begin
        if (ov[0] && r < 4) begin got[r] = od[0]; r++; end
        step();
        n++;
      end
      acc[b] = cyc;
      step();
    end
    iv[0] = 1'b0;
    n = 0;
    while (r < 4 && n < 50) begin
      if (ov[0]) begin got[r] = od[0]; r++; end
      step();
      n++;
    end
    for (int b = 0; b < 4; b++) begin
      check("b2b_data", 160'(got[b]),
            160'(bm[b] ? model_dec(bd[b], key, 4)
                       : model_enc(bd[b], key, 4)));
      if (b > 0)
        check("b2b_spacing", 160'(acc[b] - acc[b-1]), 160'(12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
